pipe_chain: RTL

- Parametrised, elastic replacement for the fixed per-stage CPU pipeline registers (Mem/Ex/WB).
- Carries a control field (write/read enables, jump flags, ALU op) and a data field through STAGES register stages, with a valid/ready handshake, backpressure stalls and per-stage selective flush.
- A stage that holds a bubble presents an all-zero control field, so downstream write enables stay inactive.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_chain_if.sv | 44 ++++
 rtl/pipe_stage.sv | 55 +++++
 rtl/pipe_chain.sv | 99 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline register chain
// Purpose : control-field layout carried down the chain, sizing limits and the
//           saturating increment used by the optional performance counters
//           (PIPE_CHAIN_PERF_CNT_EN).
// Ports   : none (package)
package pipe_pkg;

   typedef struct packed {
      logic       wmem;
      logic       rmem;
      logic       wreg;
      logic       wpc;
      logic [1:0] jmpf;
      logic [2:0] alu_ins;
   } ctrl_t;

   localparam int CTRL_W_DEF = $bits(ctrl_t);
   localparam int MAX_STAGES = 8;
   localparam int PERF_CNT_W = 16;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (&v) ? v : v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// rtl/pipe_chain_if.sv - handshake bundle between producer/consumer and the pipe chain
// Purpose : groups the input word, output word, flush and status signals.
//           With PIPE_CHAIN_PERF_CNT_EN defined, stall_cnt/kill_cnt are added.
// Ports   : master = producer/consumer side (drives in_*, flush, out_ready)
//           slave  = chain side (drives in_ready, out_*, stage_valid[, counters])
interface pipe_chain_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = 96,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int STAGES = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic [STAGES-1:0] flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [STAGES-1:0] stage_valid;
`ifdef PIPE_CHAIN_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cnt;
   logic [PERF_CNT_W-1:0] kill_cnt;
`endif

   modport master (
      output in_valid, in_ctrl, in_data, flush, out_ready,
`ifdef PIPE_CHAIN_PERF_CNT_EN
      input  stall_cnt, kill_cnt,
`endif
      input  in_ready, out_valid, out_ctrl, out_data, stage_valid
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, flush, out_ready,
`ifdef PIPE_CHAIN_PERF_CNT_EN
      output stall_cnt, kill_cnt,
`endif
      output in_ready, out_valid, out_ctrl, out_data, stage_valid
   );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one elastic register stage (valid + ctrl + data)
// Purpose : loads the upstream item when i_load is high; an incoming bubble
//           clears ctrl but leaves data untouched to avoid needless toggling.
// Ports   : clk, rst          clock, synchronous active-high reset
//           i_load            downstream ready for this stage
//           i_valid           incoming item is live
//           i_ctrl, i_data    incoming item
//           i_flush           kill the item currently held here
//           o_valid           raw valid bit
//           o_live            valid and not being flushed this cycle
//           o_ctrl, o_data    held item
module pipe_stage #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_flush,
   output logic              o_valid,
   output logic              o_live,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);
   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // A stage that is not loaded is necessarily live (hence not flushed), so
   // a stalled stage never needs its own flush handling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
         end else begin
            r_ctrl <= '0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_live  = r_valid & ~i_flush;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - parametrised elastic pipeline register chain with flush
// Purpose : carries ctrl/data through STAGES register stages with valid/ready
//           backpressure and per-stage kill. Optional PIPE_CHAIN_PERF_CNT_EN
//           adds saturating stall and kill counters.
// Ports   : clk, rst   clock, synchronous active-high reset
//           bus        pipe_chain_if.slave (in_*, out_*, flush, stage_valid)
module pipe_chain
   import pipe_pkg::*;
#(
   parameter int DATA_W = 96,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int STAGES = 3
) (
   input  logic        clk,
   input  logic        rst,
   pipe_chain_if.slave bus
);
   logic [STAGES-1:0] w_valid;
   logic [STAGES-1:0] w_live;
   logic [STAGES-1:0] w_rdy;
   logic [CTRL_W-1:0] w_ctrl [STAGES];
   logic [DATA_W-1:0] w_data [STAGES];

   // A stage may load when it holds nothing live or anything downstream can
   // move; the accumulator folds that OR from the output back to the input.
   always_comb begin : ready_ripple
      logic v_acc;
      v_acc = bus.out_ready;
      w_rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         v_acc    = v_acc | ~w_live[k];
         w_rdy[k] = v_acc;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic              w_in_valid;
      logic [CTRL_W-1:0] w_in_ctrl;
      logic [DATA_W-1:0] w_in_data;

      if (k == 0) begin : g_head
         assign w_in_valid = bus.in_valid;
         assign w_in_ctrl  = bus.in_ctrl;
         assign w_in_data  = bus.in_data;
      end else begin : g_body
         // A flushed upstream item arrives as a bubble.
         assign w_in_valid = w_live[k-1];
         assign w_in_ctrl  = w_ctrl[k-1];
         assign w_in_data  = w_data[k-1];
      end

      pipe_stage #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_rdy[k]),
         .i_valid (w_in_valid),
         .i_ctrl  (w_in_ctrl),
         .i_data  (w_in_data),
         .i_flush (bus.flush[k]),
         .o_valid (w_valid[k]),
         .o_live  (w_live[k]),
         .o_ctrl  (w_ctrl[k]),
         .o_data  (w_data[k])
      );
   end

   assign bus.in_ready    = w_rdy[0];
   assign bus.out_valid   = w_live[STAGES-1];
   assign bus.out_ctrl    = w_live[STAGES-1] ? w_ctrl[STAGES-1] : '0;
   assign bus.out_data    = w_data[STAGES-1];
   assign bus.stage_valid = w_valid;

`ifdef PIPE_CHAIN_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] r_stall_cnt;
   logic [PERF_CNT_W-1:0] r_kill_cnt;

   // One kill event per cycle no matter how many stages are flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_kill_cnt  <= '0;
      end else begin
         if (bus.in_valid && !w_rdy[0]) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end
         if (|(w_valid & bus.flush)) begin
            r_kill_cnt <= sat_inc(r_kill_cnt);
         end
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.kill_cnt  = r_kill_cnt;
`endif

endmodule
